count_ctrl: RTL and testbench

- Upstream stage of the seven-segment display path in the seg7_counter design.
- Turns three raw push-buttons (start/stop, direction, clear) into a debounced, prescaled decimal up/down count, 0..MAX_COUNT.
- Drives the 16-bit binary Data word that the display scanner converts to digits.
- Provides run/direction status for the board LEDs.

---
 rtl/count_ctrl_if.sv | 22 ++
 rtl/count_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_count_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/count_ctrl_if.sv
// count_ctrl_if: button inputs and count/status outputs of count_ctrl.
// Signal names match the board-level names used by the seg7_counter design.
// The slave modport is the counter's view; master is the board/bench side.
interface count_ctrl_if;
    logic        btn_start;
    logic        btn_dir;
    logic        btn_clear;
    logic [15:0] Data;
    logic        running;
    logic        dir_up;
    logic        wrap_pulse;

    modport master (
        output btn_start, btn_dir, btn_clear,
        input  Data, running, dir_up, wrap_pulse
    );

    modport slave (
        input  btn_start, btn_dir, btn_clear,
        output Data, running, dir_up, wrap_pulse
    );
endinterface

// File: rtl/count_ctrl.sv
// count_ctrl: debounced push-button control of a prescaled decimal up/down
// counter (0..MAX_COUNT) feeding the seven-segment display scanner.
// Optional build macro COUNT_SATURATE_EN: the count holds at MAX_COUNT
// going up and at 0 going down instead of wrapping, and wrap_pulse stays 0.
module count_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int MAX_COUNT  = 999
) (
    input  logic        clk,
    input  logic        rtsn,
    count_ctrl_if.slave bus
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam int PRE_W = $clog2(TICK_DIV);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [15:0]      DATA_MAX = 16'(MAX_COUNT);

    // Bit positions of the three buttons in the conditioning vectors
    localparam int B_START = 0;
    localparam int B_DIR   = 1;
    localparam int B_CLEAR = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    logic [2:0]       w_btn_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_deb_lvl;
    logic [DEB_W-1:0] r_deb_cnt [3];
    logic [2:0]       w_press;

    state_t           r_state;
    logic [PRE_W-1:0] r_presc;
    logic [15:0]      r_data;
    logic             r_running;
    logic             r_dir_up;
    logic             r_wrap;

    logic [15:0]      w_next_data;
    logic             w_wrap;

    assign w_btn_raw = {bus.btn_clear, bus.btn_dir, bus.btn_start};

    // Two-flop synchroniser bringing the raw buttons into the clk domain
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would collapse the two stages.
        if (!rtsn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level after the synced sample has differed
    // from the accepted level for DEB_CYCLES consecutive samples
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            // NOTE: this small counter array is reset like any other flop;
            // it is control state, not a storage memory, so it must start at 0.
            if (!rtsn) begin
                r_deb_lvl[i] <= 1'b0;
                r_deb_cnt[i] <= '0;
            end else if (r_sync2[i] == r_deb_lvl[i]) begin
                r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == DEB_LAST) begin
                r_deb_lvl[i] <= r_sync2[i];
                r_deb_cnt[i] <= '0;
            end else begin
                r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
            end
        end
    end

    // Press pulse: high in the cycle whose edge raises the debounced level
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_press = '0;
        for (int i = 0; i < 3; i++) begin
            w_press[i] = r_sync2[i] & ~r_deb_lvl[i] & (r_deb_cnt[i] == DEB_LAST);
        end
    end

    // Next count value for a tick, using the current (pre-toggle) direction
    always_comb begin
        w_next_data = r_data;
        w_wrap      = 1'b0;
        if (r_dir_up) begin
            if (r_data >= DATA_MAX) begin
`ifdef COUNT_SATURATE_EN
                w_next_data = DATA_MAX;
`else
                w_next_data = '0;
                w_wrap      = 1'b1;
`endif
            end else begin
                w_next_data = r_data + 16'd1;
            end
        end else begin
            if (r_data == '0) begin
`ifdef COUNT_SATURATE_EN
                w_next_data = '0;
`else
                w_next_data = DATA_MAX;
                w_wrap      = 1'b1;
`endif
            end else begin
                w_next_data = r_data - 16'd1;
            end
        end
    end

    // Control FSM with prescaler, count, direction and registered status
    always_ff @(posedge clk) begin
        if (!rtsn) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_data    <= '0;
            r_running <= 1'b0;
            r_dir_up  <= 1'b1;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= 1'b0;

            // Direction toggles in any state; a same-cycle tick already
            // used the old value through w_next_data.
            if (w_press[B_DIR]) begin
                r_dir_up <= ~r_dir_up;
            end

            if (w_press[B_CLEAR]) begin
                // Clear overrides start and any tick in the same cycle
                r_state   <= S_IDLE;
                r_presc   <= '0;
                r_data    <= '0;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_press[B_START]) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                            r_presc   <= '0;
                        end
                    end
                    S_RUN: begin
                        if (r_presc == PRE_LAST) begin
                            r_presc <= '0;
                            r_data  <= w_next_data;
                            r_wrap  <= w_wrap;
                        end else begin
                            r_presc <= r_presc + PRE_W'(1);
                        end
                        // A tick on the pause edge is still applied above
                        if (w_press[B_START]) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                    S_PAUSE: begin
                        // Count and prescaler frozen; resume keeps the phase
                        if (w_press[B_START]) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.Data       = r_data;
    assign bus.running    = r_running;
    assign bus.dir_up     = r_dir_up;
    assign bus.wrap_pulse = r_wrap;

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed bench for count_ctrl with TICK_DIV=4,
// DEB_CYCLES=3, MAX_COUNT=9. Build with COUNT_SATURATE_EN defined to
// select the saturating expectations in the wrap scenario.
module tb_count_ctrl;

    logic clk;
    logic rtsn;
    int   n_cmp;
    int   n_err;
    int   wrap_cnt;
    int   wrap_base;
    int   bad_cycles;

    count_ctrl_if bus_if ();

    count_ctrl #(
        .TICK_DIV   (4),
        .DEB_CYCLES (3),
        .MAX_COUNT  (9)
    ) u_dut (
        .clk  (clk),
        .rtsn (rtsn),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which wrap_pulse is seen high
    initial wrap_cnt = 0;
    always @(negedge clk) begin
        if (bus_if.wrap_pulse === 1'b1) wrap_cnt <= wrap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold buttons {clear,dir,start} for 5 edges (their press takes effect
    // on the 5th edge), then release them all
    task automatic hold_press(input logic [2:0] m);
        bus_if.btn_start = m[0];
        bus_if.btn_dir   = m[1];
        bus_if.btn_clear = m[2];
        cyc(5);
        bus_if.btn_start = 1'b0;
        bus_if.btn_dir   = 1'b0;
        bus_if.btn_clear = 1'b0;
    endtask

    task automatic do_reset();
        rtsn             = 1'b0;
        bus_if.btn_start = 1'b0;
        bus_if.btn_dir   = 1'b0;
        bus_if.btn_clear = 1'b0;
        cyc(2);
        rtsn = 1'b1;
        cyc(1);
    endtask

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        rtsn             = 1'b0;
        bus_if.btn_start = 1'b0;
        bus_if.btn_dir   = 1'b0;
        bus_if.btn_clear = 1'b0;

        // Reset values
        cyc(2);
        check("rst_data",    bus_if.Data,       0);
        check("rst_running", bus_if.running,    0);
        check("rst_dir_up",  bus_if.dir_up,     1);
        check("rst_wrap",    bus_if.wrap_pulse, 0);
        rtsn = 1'b1;
        cyc(2);

        // 1: clean start press, RUN after 5 edges, steps every 4 cycles
        bus_if.btn_start = 1'b1;
        cyc(4);
        check("t1_run_early", bus_if.running, 0);
        cyc(1);                                   // E
        check("t1_run_on",  bus_if.running, 1);
        check("t1_data_e",  bus_if.Data,    0);
        bus_if.btn_start = 1'b0;
        cyc(3);                                   // E+3
        check("t1_data_e3", bus_if.Data,    0);
        cyc(1);                                   // E+4
        check("t1_data_e4", bus_if.Data,    1);
        cyc(4);                                   // E+8
        check("t1_data_e8", bus_if.Data,    2);
        check("t1_dir_up",  bus_if.dir_up,  1);
        check("t1_release", bus_if.running, 1);

        // 2: glitching start button, then stable: exactly one press
        bad_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            bus_if.btn_start = (i % 2 == 0);
            cyc(1);
            if (bus_if.running !== 1'b1) bad_cycles++;
        end
        check("t2_glitch_held", bad_cycles, 0);
        bus_if.btn_start = 1'b1;                  // t=10
        cyc(4);
        check("t2_run_t14",  bus_if.running, 1);
        cyc(1);                                   // t=15
        check("t2_paused",   bus_if.running, 0);
        check("t2_data",     bus_if.Data,    5);
        cyc(5);
        check("t2_one_pulse", bus_if.running, 0);
        check("t2_frozen",    bus_if.Data,    5);
        bus_if.btn_start = 1'b0;

        // 3: wrap (or saturate) up at 9 and down at 0
        do_reset();
        wrap_base = wrap_cnt;
        hold_press(3'b001);                       // E
        cyc(36);                                  // E+36
        check("t3_data9",  bus_if.Data,       9);
        check("t3_wrap9",  bus_if.wrap_pulse, 0);
        cyc(4);                                   // E+40
`ifdef COUNT_SATURATE_EN
        check("t3_up_hold",  bus_if.Data,       9);
        check("t3_up_nowrap", bus_if.wrap_pulse, 0);
`else
        check("t3_up_wrap",  bus_if.Data,       0);
        check("t3_wrap_hi",  bus_if.wrap_pulse, 1);
`endif
        cyc(1);                                   // E+41
        check("t3_wrap_lo",  bus_if.wrap_pulse, 0);
        hold_press(3'b010);                       // E+46
        check("t3_dir_down", bus_if.dir_up,     0);
`ifdef COUNT_SATURATE_EN
        cyc(2);                                   // E+48
        check("t3_down8",    bus_if.Data,       8);
        cyc(32);                                  // E+80
        check("t3_down0",    bus_if.Data,       0);
        cyc(4);                                   // E+84
        check("t3_dn_hold",  bus_if.Data,       0);
        check("t3_still_run", bus_if.running,   1);
        check("t3_wrap_cnt", wrap_cnt - wrap_base, 0);
`else
        cyc(2);                                   // E+48
        check("t3_down0",    bus_if.Data,       0);
        cyc(4);                                   // E+52
        check("t3_dn_wrap",  bus_if.Data,       9);
        check("t3_dn_whi",   bus_if.wrap_pulse, 1);
        cyc(1);
        check("t3_dn_wlo",   bus_if.wrap_pulse, 0);
        check("t3_wrap_cnt", wrap_cnt - wrap_base, 2);
`endif

        // 4: pause with prescaler at 2, resume keeps the phase
        do_reset();
        hold_press(3'b001);                       // E
        cyc(5);
        hold_press(3'b001);                       // E+10
        check("t4_paused",   bus_if.running, 0);
        check("t4_data_p",   bus_if.Data,    2);
        cyc(20);
        check("t4_frozen",   bus_if.Data,    2);
        check("t4_still_p",  bus_if.running, 0);
        hold_press(3'b001);                       // R
        check("t4_resumed",  bus_if.running, 1);
        cyc(1);
        check("t4_data_r1",  bus_if.Data,    2);
        cyc(1);
        check("t4_data_r2",  bus_if.Data,    3);

        // 5: clear and start in the same cycle while paused at 6
        do_reset();
        hold_press(3'b001);                       // E
        cyc(20);
        hold_press(3'b001);                       // E+25
        check("t5_paused",   bus_if.running, 0);
        check("t5_data6",    bus_if.Data,    6);
        hold_press(3'b010);                       // E+30
        check("t5_dir_dn",   bus_if.dir_up,  0);
        hold_press(3'b101);                       // E+35
        check("t5_run_off",  bus_if.running, 0);
        check("t5_cleared",  bus_if.Data,    0);
        check("t5_dir_keep", bus_if.dir_up,  0);
        cyc(8);
        check("t5_idle_run", bus_if.running, 0);
        check("t5_idle_dat", bus_if.Data,    0);

        // 6: one-edge reset mid-RUN at Data=5, counting down
        do_reset();
        hold_press(3'b001);                       // E
        cyc(16);
        hold_press(3'b010);                       // E+21
        check("t6_pre_data", bus_if.Data,    5);
        check("t6_pre_dir",  bus_if.dir_up,  0);
        check("t6_pre_run",  bus_if.running, 1);
        rtsn = 1'b0;
        cyc(1);
        check("t6_rst_data", bus_if.Data,       0);
        check("t6_rst_dir",  bus_if.dir_up,     1);
        check("t6_rst_run",  bus_if.running,    0);
        check("t6_rst_wrap", bus_if.wrap_pulse, 0);
        rtsn = 1'b1;
        cyc(4);
        check("t6_no_step",  bus_if.Data,    0);
        check("t6_idle",     bus_if.running, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
